uart_tx_fifo: RTL and testbench

- UART transmitter with a small input FIFO. It serialises bytes onto the tx line as 8N1 frames, LSB first, one stop bit.
- It is the transmit-side partner of the existing receiver and shares its baud convention (DELAY_FRAMES clocks per bit at 27 MHz).
- Upstream logic pushes bytes with a valid/ready handshake.
- The serial output drives the board uart_tx pin, or a receiver input in loopback.

---
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Upstream byte handshake plus the serial line and status outputs of the
// UART transmitter, bundled so producer and transmitter share one port.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 2
);
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             uart_tx;
    logic             tx_busy;
    logic [FIFO_AW:0] fifo_count;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  uart_tx,
        input  tx_busy,
        input  fifo_count
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output uart_tx,
        output tx_busy,
        output fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed from a small FIFO. Back-to-back
// bytes are sent with no idle gap between stop bit and next start bit.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_AW      = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int               DEPTH_INT = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH     = (FIFO_AW+1)'(DEPTH_INT);
    localparam int               BW        = $clog2(DELAY_FRAMES + 1);
    localparam logic [BW-1:0]    BAUD_MAX  = BW'(DELAY_FRAMES);
    localparam logic [BW-1:0]    BAUD_ONE  = BW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]         r_mem [DEPTH_INT];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [1:0]         r_state;
    logic [BW-1:0]      r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic w_ready;
    logic w_push;
    logic w_bitEnd;
    logic w_pop;

    assign w_ready  = (r_count != DEPTH);
    assign w_push   = bus.tx_valid && w_ready;
    assign w_bitEnd = (r_baud == BAUD_MAX);
    // A byte is taken either from idle or on the final stop cycle, giving gapless frames.
    assign w_pop    = (r_count != '0) &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bitEnd));

    assign bus.tx_ready   = w_ready;
    assign bus.uart_tx    = r_tx;
    assign bus.tx_busy    = (r_state != S_IDLE) || (r_count != '0);
    assign bus.fifo_count = r_count;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // r_tx always carries the level of the bit that starts on this edge.
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_baud  <= BAUD_ONE;
                        r_shift <= r_mem[r_rptr];
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bitEnd) begin
                        r_state <= S_DATA;
                        r_baud  <= BAUD_ONE;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bitEnd) begin
                        r_baud <= BAUD_ONE;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bitEnd) begin
                        if (w_pop) begin
                            r_state <= S_START;
                            r_baud  <= BAUD_ONE;
                            r_shift <= r_mem[r_rptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_baud  <= '0;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random pushes,
// compared every cycle against a frame-level model of queue and line.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int D     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * D;

    logic sysClk;
    logic sysRstN;

    uart_tx_fifo_if #(.FIFO_AW(AW)) bus ();

    uart_tx_fifo #(
        .DELAY_FRAMES(D),
        .FIFO_AW     (AW)
    ) dut (
        .sys_clk  (sysClk),
        .sys_rst_n(sysRstN),
        .bus      (bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int assertCount = 0;
    int errCount    = 0;

    logic [7:0] modelQ[$];
    logic [7:0] modelCur;
    bit         modelActive;
    int         modelT;

    // Model view: a frame is 10 bit slots of D cycles (start, 8 data LSB first, stop).
    task automatic modelStep(input logic v, input logic [7:0] d);
        bit frameEnds;
        bit doPop;
        bit doPush;
        frameEnds = modelActive && (modelT == FRAME - 1);
        doPop     = (!modelActive || frameEnds) && (modelQ.size() > 0);
        doPush    = v && (modelQ.size() < DEPTH);
        if (modelActive) begin
            modelT++;
            if (frameEnds) modelActive = 1'b0;
        end
        if (doPop) begin
            modelCur    = modelQ.pop_front();
            modelActive = 1'b1;
            modelT      = 0;
        end
        if (doPush) modelQ.push_back(d);
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelActive = 1'b0;
        modelT      = 0;
        modelCur    = 8'h00;
    endtask

    function automatic logic expLine();
        int slot;
        if (!modelActive) return 1'b1;
        slot = modelT / D;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return modelCur[slot-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int qs;
        qs = modelQ.size();
        check({tag, ".uart_tx"},    32'(bus.uart_tx),    32'(expLine()));
        check({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(qs));
        check({tag, ".tx_ready"},   32'(bus.tx_ready),   32'(qs != DEPTH));
        check({tag, ".tx_busy"},    32'(bus.tx_busy),    32'(modelActive || (qs != 0)));
    endtask

    // Drive after a falling edge, advance one rising edge, check at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input string tag);
        bus.tx_valid = v;
        bus.tx_data  = d;
        @(posedge sysClk);
        modelStep(v, d);
        @(negedge sysClk);
        bus.tx_valid = 1'b0;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), tag);
    endtask

    initial begin
        logic [7:0] burst [5];
        int         guard;
        burst = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h3C};

        sysRstN      = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        modelReset();
        @(negedge sysClk);
        @(negedge sysClk);
        checkOutput("reset");
        sysRstN = 1'b1;

        idleCycles(100, "idle");

        applyStimulus(1'b1, 8'hA5, "pushA5");
        idleCycles(90, "frameA5");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, burst[i], "burst");
        check("burst.fullReady", 32'(bus.tx_ready), 32'(0));
        applyStimulus(1'b1, 8'h99, "burstSixth");
        check("burst.sixthIgnored", 32'(bus.fifo_count), 32'(4));
        idleCycles(5 * FRAME + 10, "burstDrain");

        applyStimulus(1'b1, 8'h11, "samePush");
        applyStimulus(1'b1, 8'h22, "samePush");
        applyStimulus(1'b1, 8'h33, "samePush");
        guard = 0;
        while (!(modelActive && modelT == FRAME - 1) && guard < 4 * FRAME) begin
            applyStimulus(1'b0, 8'h00, "sameWait");
            guard++;
        end
        check("same.reachedStopEnd", 32'(guard < 4 * FRAME), 32'(1));
        applyStimulus(1'b1, 8'h44, "sameEdge");
        check("same.countHeld", 32'(bus.fifo_count), 32'(2));
        idleCycles(4 * FRAME + 10, "sameDrain");

        for (int i = 0; i < 600; i++)
            applyStimulus(1'($urandom_range(0, 3) == 0), 8'($urandom), "random");
        idleCycles(DEPTH * FRAME + FRAME + 10, "randomDrain");

        applyStimulus(1'b1, 8'hC3, "rstPush");
        applyStimulus(1'b1, 8'h5A, "rstPush");
        applyStimulus(1'b1, 8'h96, "rstPush");
        idleCycles(FRAME + 2 * D + 3, "rstRun");
        #2;
        sysRstN = 1'b0;
        #1;
        modelReset();
        check("rstAsync.uart_tx",    32'(bus.uart_tx),    32'(1));
        check("rstAsync.fifo_count", 32'(bus.fifo_count), 32'(0));
        check("rstAsync.tx_busy",    32'(bus.tx_busy),    32'(0));
        check("rstAsync.tx_ready",   32'(bus.tx_ready),   32'(1));
        @(negedge sysClk);
        @(negedge sysClk);
        sysRstN = 1'b1;
        idleCycles(3 * FRAME, "afterReset");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
        $finish;
    end
endmodule
